// File: rtl/spectag_allocator_pkg.sv
// Shared speculative-tag types, limits and one-hot rotate helpers.
// Used by the allocator and the miss-prediction fix table.
package spectag_allocator_pkg;
    localparam int SPECTAG_LEN     = 5;
    localparam int MAX_OUTSTANDING = 5;

    typedef logic [SPECTAG_LEN-1:0] spectag_t;
    typedef logic [2:0]             cnt_t;

    function automatic spectag_t spectag_next(input spectag_t t);
        return {t[SPECTAG_LEN-2:0], t[SPECTAG_LEN-1]};
    endfunction

    function automatic spectag_t spectag_prev(input spectag_t t);
        return {t[0], t[SPECTAG_LEN-1:1]};
    endfunction
endpackage

// File: rtl/spectag_allocator_if.sv
// Decode/resolve bundle between rename and the speculative-tag allocator.
// full_cycles exists only when SPECTAG_STATS_EN is defined.
interface spectag_allocator_if;
    import spectag_allocator_pkg::*;

    logic     inst1_isbranch;
    logic     inst2_isbranch;
    logic     inst1_inv;
    logic     inst2_inv;
    logic     stall_in;
    logic     prsuccess;
    logic     prmiss;
    spectag_t prmiss_tag;
    spectag_t inst1_spectag;
    spectag_t inst2_spectag;
    spectag_t setspec1_tag;
    spectag_t setspec2_tag;
    logic     setspec1_en;
    logic     setspec2_en;
    logic     branch_full;
    cnt_t     outstanding;
`ifdef SPECTAG_STATS_EN
    logic [15:0] full_cycles;
`endif

    modport master (
        output inst1_isbranch, inst2_isbranch, inst1_inv, inst2_inv,
               stall_in, prsuccess, prmiss, prmiss_tag,
        input  inst1_spectag, inst2_spectag, setspec1_tag, setspec2_tag,
               setspec1_en, setspec2_en, branch_full, outstanding
`ifdef SPECTAG_STATS_EN
        , input full_cycles
`endif
    );

    modport slave (
        input  inst1_isbranch, inst2_isbranch, inst1_inv, inst2_inv,
               stall_in, prsuccess, prmiss, prmiss_tag,
        output inst1_spectag, inst2_spectag, setspec1_tag, setspec2_tag,
               setspec1_en, setspec2_en, branch_full, outstanding
`ifdef SPECTAG_STATS_EN
        , output full_cycles
`endif
    );
endinterface

// File: rtl/spectag_allocator.sv
// Speculative branch tag allocator for a 2-wide decode pair; outputs are combinational, state updates next edge.
// Pair allocates atomically or stalls via branch_full; SPECTAG_STATS_EN adds a saturating full-cycle counter.
module spectag_allocator
    import spectag_allocator_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    spectag_allocator_if.slave  bus
);
    spectag_t   r_cur_tag;
    cnt_t       r_cnt;

    logic       w_b1;
    logic       w_b2;
    logic [1:0] w_nreq;
    logic [3:0] w_sum;
    logic       w_full;
    logic       w_alloc;
    spectag_t   w_tag1;
    spectag_t   w_tag2;
    cnt_t       w_base;
    cnt_t       w_cnt_nx;

    assign w_b1    = bus.inst1_isbranch & ~bus.inst1_inv;
    assign w_b2    = bus.inst2_isbranch & ~bus.inst2_inv;
    assign w_nreq  = {1'b0, w_b1} + {1'b0, w_b2};
    // Same-cycle prsuccess is deliberately not credited against the limit.
    assign w_sum   = {1'b0, r_cnt} + {2'b00, w_nreq};
    assign w_full  = w_sum > 4'(MAX_OUTSTANDING);
    assign w_alloc = ~w_full & ~bus.stall_in & ~bus.prmiss;
    assign w_tag1  = w_b1 ? spectag_next(r_cur_tag) : r_cur_tag;
    assign w_tag2  = w_b2 ? spectag_next(w_tag1) : w_tag1;

    assign bus.inst1_spectag = w_tag1;
    assign bus.inst2_spectag = w_tag2;
    assign bus.setspec1_tag  = w_tag1;
    assign bus.setspec2_tag  = w_tag2;
    assign bus.setspec1_en   = w_b1 & w_alloc;
    assign bus.setspec2_en   = w_b2 & w_alloc;
    assign bus.branch_full   = w_full;
    assign bus.outstanding   = r_cnt;

    always_comb begin
        w_base   = w_alloc ? w_sum[2:0] : r_cnt;
        w_cnt_nx = w_base;
        if (bus.prsuccess && (w_base != 3'd0)) begin
            w_cnt_nx = w_base - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_tag <= spectag_t'(1);
            r_cnt     <= '0;
        end else if (bus.prmiss) begin
            r_cur_tag <= spectag_prev(bus.prmiss_tag);
            r_cnt     <= '0;
        end else begin
            if (w_alloc) begin
                r_cur_tag <= w_tag2;
            end
            r_cnt <= w_cnt_nx;
        end
    end

`ifdef SPECTAG_STATS_EN
    logic [15:0] r_full_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full_cycles <= '0;
        end else if (w_full && (w_nreq != 2'd0) && !bus.stall_in
                     && (r_full_cycles != 16'hFFFF)) begin
            r_full_cycles <= r_full_cycles + 16'd1;
        end
    end

    assign bus.full_cycles = r_full_cycles;
`endif

`ifndef SYNTHESIS
    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        ($onehot(r_cur_tag) && (r_cnt <= 3'(MAX_OUTSTANDING))));
`endif
endmodule

// File: tb/tb_spectag_allocator.sv
// Bench for spectag_allocator: directed scenarios plus random traffic against an index-based tag model.
module tb_spectag_allocator;
    logic clk;
    logic reset;

    spectag_allocator_if bus ();

    spectag_allocator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  t1;
        logic [4:0]  t2;
        logic        e1;
        logic        e2;
        logic        full;
        logic [2:0]  outst;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: tag position 0..4 and outstanding count.
    int m_pos = 0;
    int m_cnt = 0;
    int m_fc  = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive(input bit isb1, input bit inv1, input bit isb2, input bit inv2,
                         input bit stall, input bit prs, input bit prm, input int mi,
                         input bit rst_v);
        int   n, p1, p2, tot;
        bit   b1, b2, full, alloc;
        exp_t e;
        reset              = rst_v;
        bus.inst1_isbranch = isb1;
        bus.inst1_inv      = inv1;
        bus.inst2_isbranch = isb2;
        bus.inst2_inv      = inv2;
        bus.stall_in       = stall;
        bus.prsuccess      = prs;
        bus.prmiss         = prm;
        bus.prmiss_tag     = 5'(1 << mi);
        if (rst_v) begin
            m_pos = 0; m_cnt = 0; m_fc = 0;
        end
        b1    = isb1 && !inv1;
        b2    = isb2 && !inv2;
        n     = int'(b1) + int'(b2);
        full  = (m_cnt + n) > 5;
        alloc = !full && !stall && !prm;
        p1    = b1 ? (m_pos + 1) % 5 : m_pos;
        p2    = b2 ? (p1 + 1) % 5 : p1;
        e.t1    = 5'(1 << p1);
        e.t2    = 5'(1 << p2);
        e.e1    = b1 && alloc;
        e.e2    = b2 && alloc;
        e.full  = full;
        e.outst = 3'(m_cnt);
        e.fc    = 16'(m_fc);
        exp_q.push_back(e);
        if (!rst_v) begin
            if (full && n != 0 && !stall && m_fc < 65535) m_fc++;
            if (prm) begin
                m_cnt = 0;
                m_pos = (mi + 4) % 5;
            end else begin
                tot = m_cnt + (alloc ? n : 0) - (prs ? 1 : 0);
                m_cnt = (tot < 0) ? 0 : tot;
                if (alloc) m_pos = p2;
            end
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("inst1_spectag", 16'(bus.inst1_spectag), 16'(e.t1));
            cmp("inst2_spectag", 16'(bus.inst2_spectag), 16'(e.t2));
            cmp("setspec1_tag",  16'(bus.setspec1_tag),  16'(e.t1));
            cmp("setspec2_tag",  16'(bus.setspec2_tag),  16'(e.t2));
            cmp("setspec1_en",   16'(bus.setspec1_en),   16'(e.e1));
            cmp("setspec2_en",   16'(bus.setspec2_en),   16'(e.e2));
            cmp("branch_full",   16'(bus.branch_full),   16'(e.full));
            cmp("outstanding",   16'(bus.outstanding),   16'(e.outst));
`ifdef SPECTAG_STATS_EN
            cmp("full_cycles",   bus.full_cycles,        e.fc);
`endif
        end
    end

    initial begin
        int cyc;
        reset              = 1'b1;
        bus.inst1_isbranch = 1'b0;
        bus.inst1_inv      = 1'b0;
        bus.inst2_isbranch = 1'b0;
        bus.inst2_inv      = 1'b0;
        bus.stall_in       = 1'b0;
        bus.prsuccess      = 1'b0;
        bus.prmiss         = 1'b0;
        bus.prmiss_tag     = 5'b00001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_outstanding", 16'(bus.outstanding), 16'd0);
        cmp("rst_full", 16'(bus.branch_full), 16'd0);
        cmp("rst_cur_tag", 16'(bus.inst1_spectag), 16'h01);
        tick();

        // First allocation after reset.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cmp("first_tag", 16'(bus.inst1_spectag), 16'h02);
        cmp("first_en", 16'(bus.setspec1_en), 16'd1);
        tick();
        idle();
        @(negedge clk);
        cmp("first_outst", 16'(bus.outstanding), 16'd1);
        cmp("first_cur", 16'(bus.inst1_spectag), 16'h02);
        tick();

        // Fill to four, then a pair must be refused.
        repeat (3) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cmp("full4_flag", 16'(bus.branch_full), 16'd1);
        cmp("full4_en", {14'd0, bus.setspec1_en, bus.setspec2_en}, 16'd0);
        tick();
        drive(1, 0, 1, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        cmp("full4_prs_flag", 16'(bus.branch_full), 16'd1);
        tick();
        idle();
        @(negedge clk);
        cmp("full4_prs_cnt", 16'(bus.outstanding), 16'd3);
        tick();
        repeat (3) begin drive(0, 0, 0, 0, 0, 1, 0, 0, 0); tick(); end

        // Wrap from 10000 with a pair.
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cmp("wrap_t1", 16'(bus.inst1_spectag), 16'h01);
        cmp("wrap_t2", 16'(bus.inst2_spectag), 16'h02);
        cmp("wrap_en", {14'd0, bus.setspec1_en, bus.setspec2_en}, 16'd3);
        tick();
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        idle();
        @(negedge clk);
        cmp("prs_alloc_cnt", 16'(bus.outstanding), 16'd2);
        cmp("prs_alloc_cur", 16'(bus.inst1_spectag), 16'h04);
        tick();
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        cmp("stall_en", 16'(bus.setspec1_en), 16'd0);
        tick();

        // Misprediction recovery: reach cnt=3 at 01000, then miss on 00100.
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        repeat (3) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
        drive(1, 0, 1, 0, 0, 0, 1, 2, 0);
        @(negedge clk);
        cmp("miss_pre_cnt", 16'(bus.outstanding), 16'd3);
        cmp("miss_en", {14'd0, bus.setspec1_en, bus.setspec2_en}, 16'd0);
        tick();
        idle();
        @(negedge clk);
        cmp("miss_cnt", 16'(bus.outstanding), 16'd0);
        cmp("miss_cur", 16'(bus.inst1_spectag), 16'h02);
        tick();

        // Full-cycle statistics and reset mid-run.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        repeat (2) begin drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick(); end
        repeat (3) begin drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick(); end
        idle();
`ifdef SPECTAG_STATS_EN
        @(negedge clk);
        cmp("stats_three", bus.full_cycles, 16'd3);
`endif
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        cmp("midrst_outst", 16'(bus.outstanding), 16'd0);
        cmp("midrst_en", 16'(bus.setspec1_en), 16'd1);
`ifdef SPECTAG_STATS_EN
        cmp("midrst_stats", bus.full_cycles, 16'd0);
`endif
        tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) < 50, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 6, int'($urandom_range(0, 4)),
                  $urandom_range(0, 199) == 0);
            tick();
        end
        idle();

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 10) begin
            @(posedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
